irq_sched: RTL and testbench

- Priority interrupt controller between the IO block's sticky interrupt flags (GPIO irq0/irq6/irq7, timers, UART) and the CPU's single interrupt input.
- Masks and prioritises up to 8 level sources, tracks in-service state for nesting, and runs an intreq/inta handshake with the CPU.
- Supplies a registered vector to the CPU.
- Configured by the CPU over the same 8-bit IO register bus used by the GPIO block (addr/data_in/data_out/bus_cyc/bus_we).

---
 rtl/irq_sched_pkg.sv | 18 +
 rtl/irq_prio_enc.sv | 32 +++
 rtl/irq_sched.sv | 144 ++++++++++++++
 tb/tb_irq_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_sched_pkg.sv
// rtl/irq_sched_pkg.sv - shared register map, FSM encoding and constants for irq_sched
package irq_sched_pkg;

    localparam logic [2:0] IRQ_MASK  = 3'd0;
    localparam logic [2:0] IRQ_PEND  = 3'd1;
    localparam logic [2:0] IRQ_ISR   = 3'd2;
    localparam logic [2:0] IRQ_VBASE = 3'd3;
    localparam logic [2:0] IRQ_CTRL  = 3'd4;

    localparam logic [7:0] IRQ_UNMAPPED = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKW = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - picks the highest pending source above the highest in-service level
module irq_prio_enc (
    input  logic [7:0] pend,
    input  logic [7:0] isr,
    output logic       found,
    output logic [2:0] idx
);

    logic [7:0] allow;

    always_comb begin
        allow = 8'hFF;
        // Only bits strictly above the highest in-service bit may preempt.
        for (int i = 0; i < 8; i++) begin
            if (isr[i]) begin
                allow = ~((8'd2 << i) - 8'd1);
            end
        end
    end

    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i] && allow[i]) begin
                found = 1'b1;
                idx   = i[2:0];
            end
        end
    end

endmodule

// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - priority interrupt controller with nesting and intreq/inta handshake
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter int         NUM_SRC   = 8,
    parameter logic [7:0] RST_VBASE = 8'h00
) (
    input  logic               wb_clk_i,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [2:0]         addr,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic               bus_cyc,
    input  logic               bus_we,
    output logic               cpu_intreq,
    input  logic               cpu_inta,
    output logic [7:0]         int_vector,
    output logic               int_active
);

    logic [7:0] mask;
    logic [7:0] isr;
    logic [7:0] vbase;
    logic       gie;
    logic [2:0] cur;

    irq_state_e state, state_nxt;
    logic [2:0] cur_nxt;
    logic       intreq_nxt;
    logic [7:0] vec_nxt;
    logic [7:0] isr_set;
    logic [7:0] eoi_clr;

    logic [7:0] src8;
    logic [7:0] pend;
    logic       cand_found;
    logic [2:0] cand_idx;
    logic       cand_valid;
    logic [7:0] rd_data;
    logic       bus_wr;

    always_comb begin
        src8              = 8'h00;
        src8[NUM_SRC-1:0] = irq_src;
    end

    assign pend       = src8 & mask;
    assign cand_valid = cand_found && gie;
    assign bus_wr     = bus_cyc && bus_we;
    assign eoi_clr    = (bus_wr && addr == IRQ_ISR) ? data_in : 8'h00;
    assign int_active = |isr;

    irq_prio_enc u_enc (
        .pend  (pend),
        .isr   (isr),
        .found (cand_found),
        .idx   (cand_idx)
    );

    always_comb begin
        case (addr)
            IRQ_MASK:  rd_data = mask;
            IRQ_PEND:  rd_data = pend;
            IRQ_ISR:   rd_data = isr;
            IRQ_VBASE: rd_data = vbase;
            IRQ_CTRL:  rd_data = {7'b0, gie};
            default:   rd_data = IRQ_UNMAPPED;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur;
        intreq_nxt = cpu_intreq;
        vec_nxt    = int_vector;
        isr_set    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (cand_valid) begin
                    cur_nxt    = cand_idx;
                    intreq_nxt = 1'b1;
                    state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                // Acknowledge wins over a simultaneous cancellation.
                if (cpu_inta) begin
                    isr_set    = 8'h01 << cur;
                    vec_nxt    = vbase + {4'b0, cur, 1'b0};
                    intreq_nxt = 1'b0;
                    state_nxt  = ST_ACKW;
                end else if (!cand_valid) begin
                    intreq_nxt = 1'b0;
                    state_nxt  = ST_IDLE;
                end else if (cand_idx > cur) begin
                    cur_nxt = cand_idx;
                end
            end
            ST_ACKW: begin
                if (!cpu_inta) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                intreq_nxt = 1'b0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur        <= 3'd0;
            cpu_intreq <= 1'b0;
            int_vector <= 8'h00;
            isr        <= 8'h00;
            mask       <= 8'h00;
            vbase      <= RST_VBASE;
            gie        <= 1'b0;
            data_out   <= 8'h00;
        end else begin
            state      <= state_nxt;
            cur        <= cur_nxt;
            cpu_intreq <= intreq_nxt;
            int_vector <= vec_nxt;
            // A set from acknowledge beats an EOI clear of the same bit.
            isr        <= (isr & ~eoi_clr) | isr_set;
            if (bus_cyc) begin
                data_out <= rd_data;
            end
            if (bus_wr) begin
                case (addr)
                    IRQ_MASK:  mask  <= data_in;
                    IRQ_VBASE: vbase <= data_in;
                    IRQ_CTRL:  gie   <= data_in[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_sched.sv
// tb/tb_irq_sched.sv - directed and randomized checks of irq_sched against a behavioural model
module tb_irq_sched;

    localparam logic [7:0] RV = 8'h20;

    logic       wb_clk_i = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] irq_src  = 8'h00;
    logic [2:0] addr     = 3'd0;
    logic [7:0] data_in  = 8'h00;
    logic [7:0] data_out;
    logic       bus_cyc  = 1'b0;
    logic       bus_we   = 1'b0;
    logic       cpu_intreq;
    logic       cpu_inta = 1'b0;
    logic [7:0] int_vector;
    logic       int_active;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mask, m_isr, m_vbase, m_vec, m_dout;
    logic       m_gie, m_req;
    int         m_st;
    int         m_cur;

    irq_sched #(.NUM_SRC(8), .RST_VBASE(RV)) dut (
        .wb_clk_i   (wb_clk_i),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .bus_cyc    (bus_cyc),
        .bus_we     (bus_we),
        .cpu_intreq (cpu_intreq),
        .cpu_inta   (cpu_inta),
        .int_vector (int_vector),
        .int_active (int_active)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mask = 8'h00; m_isr = 8'h00; m_vbase = RV; m_vec = 8'h00; m_dout = 8'h00;
        m_gie = 1'b0; m_req = 1'b0; m_st = 0; m_cur = 0;
    endtask

    // Highest enabled requesting source strictly above the top in-service level; -1 if none.
    function automatic int cand();
        int top = -1;
        for (int i = 0; i < 8; i++) if (m_isr[i]) top = i;
        if (!m_gie) return -1;
        for (int i = 7; i > top; i--) if (irq_src[i] && m_mask[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        int c;
        int n_st, n_cur;
        logic n_req, n_gie;
        logic [7:0] n_vec, n_dout, n_mask, n_vbase, setb, eoi;
        c = cand();
        n_st = m_st; n_cur = m_cur; n_req = m_req; n_vec = m_vec;
        n_dout = m_dout; n_mask = m_mask; n_vbase = m_vbase; n_gie = m_gie;
        setb = 8'h00; eoi = 8'h00;
        if (m_st == 0) begin
            if (c >= 0) begin n_cur = c; n_req = 1'b1; n_st = 1; end
        end else if (m_st == 1) begin
            if (cpu_inta) begin
                setb[m_cur] = 1'b1;
                n_vec = m_vbase + 8'(2 * m_cur);
                n_req = 1'b0; n_st = 2;
            end else if (c < 0) begin
                n_req = 1'b0; n_st = 0;
            end else if (c > m_cur) begin
                n_cur = c;
            end
        end else begin
            if (!cpu_inta) n_st = 0;
        end
        if (bus_cyc) begin
            case (addr)
                3'd0: n_dout = m_mask;
                3'd1: n_dout = irq_src & m_mask;
                3'd2: n_dout = m_isr;
                3'd3: n_dout = m_vbase;
                3'd4: n_dout = {7'b0, m_gie};
                default: n_dout = 8'hAA;
            endcase
            if (bus_we) begin
                case (addr)
                    3'd0: n_mask = data_in;
                    3'd2: eoi = data_in;
                    3'd3: n_vbase = data_in;
                    3'd4: n_gie = data_in[0];
                    default: ;
                endcase
            end
        end
        @(posedge wb_clk_i);
        #1;
        m_st = n_st; m_cur = n_cur; m_req = n_req; m_vec = n_vec; m_dout = n_dout;
        m_mask = n_mask; m_vbase = n_vbase; m_gie = n_gie;
        m_isr = (m_isr & ~eoi) | setb;
        chk("m_intreq", {7'b0, cpu_intreq}, {7'b0, m_req});
        chk("m_vector", int_vector, m_vec);
        chk("m_active", {7'b0, int_active}, {7'b0, |m_isr});
        chk("m_dout", data_out, m_dout);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; data_in = d; bus_cyc = 1'b1; bus_we = 1'b1;
        tick();
        bus_cyc = 1'b0; bus_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        addr = a; bus_cyc = 1'b1; bus_we = 1'b0;
        tick();
        bus_cyc = 1'b0;
        chk(tag, data_out, exp);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_intreq"}, {7'b0, cpu_intreq}, 8'h00);
        chk({tag, "_active"}, {7'b0, int_active}, 8'h00);
        chk({tag, "_vector"}, int_vector, 8'h00);
        model_reset();
        cpu_inta = 1'b0;
        @(negedge wb_clk_i);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_intreq", {7'b0, cpu_intreq}, 8'h00);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_active", {7'b0, int_active}, 8'h00);
        @(negedge wb_clk_i);
        rst_n = 1'b1;

        rd(3'd0, 8'h00, "rd_mask");
        rd(3'd1, 8'h00, "rd_pend");
        rd(3'd2, 8'h00, "rd_isr");
        rd(3'd3, RV,    "rd_vbase");
        rd(3'd4, 8'h00, "rd_ctrl");
        rd(3'd6, 8'hAA, "rd_unmapped");

        // Basic request/acknowledge on irq0.
        wr(3'd0, 8'h81); wr(3'd3, 8'h40); wr(3'd4, 8'h01);
        irq_src = 8'h01; tick();
        chk("basic_req", {7'b0, cpu_intreq}, 8'h01);
        cpu_inta = 1'b1; tick();
        chk("basic_vec", int_vector, 8'h40);
        cpu_inta = 1'b0; tick();
        rd(3'd2, 8'h01, "basic_isr");
        irq_src = 8'h00; wr(3'd2, 8'h01);

        // Simultaneous irq0 and irq7.
        irq_src = 8'h81; tick();
        cpu_inta = 1'b1; tick();
        chk("sim_vec7", int_vector, 8'h4E);
        cpu_inta = 1'b0; tick();
        rd(3'd2, 8'h80, "sim_isr");
        irq_src = 8'h01; wr(3'd2, 8'h80);
        tick();
        chk("sim_req0", {7'b0, cpu_intreq}, 8'h01);
        cpu_inta = 1'b1; tick();
        chk("sim_vec0", int_vector, 8'h40);
        cpu_inta = 1'b0; tick();

        // Nesting: irq0 in service, irq7 preempts, irq0 held off.
        irq_src = 8'h81; tick();
        chk("nest_req", {7'b0, cpu_intreq}, 8'h01);
        cpu_inta = 1'b1; tick();
        chk("nest_vec", int_vector, 8'h4E);
        cpu_inta = 1'b0; tick();
        rd(3'd2, 8'h81, "nest_isr");
        irq_src = 8'h00; tick();
        irq_src = 8'h01; tick(); tick();
        chk("nest_hold", {7'b0, cpu_intreq}, 8'h00);
        irq_src = 8'h00; wr(3'd2, 8'hFF);

        // Cancel by masking.
        wr(3'd0, 8'hFF);
        irq_src = 8'h40; tick();
        chk("cancel_req", {7'b0, cpu_intreq}, 8'h01);
        wr(3'd0, 8'hBF);
        tick();
        chk("cancel_drop", {7'b0, cpu_intreq}, 8'h00);
        rd(3'd2, 8'h00, "cancel_isr");
        irq_src = 8'h00; wr(3'd0, 8'hFF);

        // Priority upgrade during REQ.
        irq_src = 8'h08; tick();
        irq_src = 8'h28; tick();
        chk("upg_req", {7'b0, cpu_intreq}, 8'h01);
        cpu_inta = 1'b1; tick();
        chk("upg_vec", int_vector, 8'h4A);
        cpu_inta = 1'b0; tick();
        irq_src = 8'h00; wr(3'd2, 8'h20);

        // Reset in REQ (with an ISR bit set) and in ACKW.
        irq_src = 8'h01; tick();
        cpu_inta = 1'b1; tick();
        cpu_inta = 1'b0; tick();
        irq_src = 8'h80; tick();
        chk("rreq_pre", {7'b0, cpu_intreq}, 8'h01);
        async_reset("rst_req");
        tick(); tick();
        wr(3'd0, 8'hFF); tick();
        chk("rst_nogie", {7'b0, cpu_intreq}, 8'h00);
        wr(3'd4, 8'h01); tick();
        chk("rst_gie_req", {7'b0, cpu_intreq}, 8'h01);
        cpu_inta = 1'b1; tick();
        async_reset("rst_ackw");
        irq_src = 8'h00;
        tick();
        wr(3'd0, 8'hFF); wr(3'd3, 8'h40); wr(3'd4, 8'h01);

        // Randomized traffic checked every cycle against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom);
            if (m_st == 1)      cpu_inta = ($urandom_range(0, 2) == 0);
            else if (m_st == 2) cpu_inta = ($urandom_range(0, 2) != 0);
            else                cpu_inta = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) begin
                addr    = 3'($urandom_range(0, 7));
                bus_we  = ($urandom_range(0, 1) == 1);
                data_in = 8'($urandom);
                if (addr == 3'd4 && $urandom_range(0, 4) != 0) data_in[0] = 1'b1;
                bus_cyc = 1'b1;
            end else begin
                bus_cyc = 1'b0;
                bus_we  = 1'b0;
            end
            tick();
        end
        bus_cyc = 1'b0; bus_we = 1'b0; cpu_inta = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
